// File: rtl/bram_read_arbiter_pkg.sv
// Shared types and helpers for the BRAM read-port arbiter: width helpers and
// the round-robin find-first used to pick the next client to issue.
package bram_read_arbiter_pkg;

  localparam int MAX_CLIENTS = 8;
  localparam int MAX_TAG_W   = 3;

  typedef struct packed {
    logic                 found;
    logic [MAX_TAG_W-1:0] idx;
  } rr_grant_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // First set bit of valid[n-1:0], scanning ptr, ptr+1, ... modulo n.
  function automatic rr_grant_t rr_find_first(
    input logic [MAX_CLIENTS-1:0] valid,
    input logic [MAX_TAG_W-1:0]   ptr,
    input int                     n
  );
    rr_grant_t g;
    int        c;
    g = '0;
    for (int k = 0; k < MAX_CLIENTS; k++) begin
      if (k < n) begin
        c = (int'(ptr) + k) % n;
        if (!g.found && valid[c[MAX_TAG_W-1:0]]) begin
          g.found = 1'b1;
          g.idx   = MAX_TAG_W'(c);
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/bram_read_arbiter_tag_fifo.sv
// Circular FIFO of client tags, one entry per in-flight BRAM read, oldest at head.
module bram_arb_tag_fifo
  import bram_read_arbiter_pkg::*;
#(
  parameter int TAG_DEPTH   = 4,
  parameter int TAG_WIDTH   = 2,
  parameter int COUNT_WIDTH = 3
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   i_push,
  input  logic [TAG_WIDTH-1:0]   i_push_tag,
  input  logic                   i_pop,
  output logic [TAG_WIDTH-1:0]   o_head_tag,
  output logic [COUNT_WIDTH-1:0] o_count
);

  localparam int                     PTR_W    = clog2_min1(TAG_DEPTH);
  localparam logic [PTR_W-1:0]       LAST_PTR = PTR_W'(TAG_DEPTH - 1);
  localparam logic [COUNT_WIDTH-1:0] FULL_CNT = COUNT_WIDTH'(TAG_DEPTH);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);

  logic [TAG_WIDTH-1:0]   r_mem [TAG_DEPTH];
  logic [PTR_W-1:0]       r_head;
  logic [PTR_W-1:0]       r_tail;
  logic [COUNT_WIDTH-1:0] r_count;
  logic                   w_push_ok;
  logic                   w_pop_ok;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_push_ok  = i_push && (r_count != FULL_CNT);
  assign w_pop_ok   = i_pop && (r_count != '0);
  assign o_head_tag = r_mem[r_head];
  assign o_count    = r_count;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_tail <= ptr_next(r_tail);
      if (w_pop_ok)  r_head <= ptr_next(r_head);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push_ok) r_mem[r_tail] <= i_push_tag;
  end

endmodule

// File: rtl/bram_read_arbiter.sv
// Shares one BRAM read port among NUM_CLIENTS requesters: 1-entry request buffer
// per client, round-robin issue, and in-order tag tracking to route responses.
module bram_read_arbiter
  import bram_read_arbiter_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int TAG_DEPTH   = 4
) (
  input  logic                              CLK,
  input  logic                              RST_N,
  input  logic [NUM_CLIENTS-1:0]            REQ_EN,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] REQ_ADDR,
  output logic [NUM_CLIENTS-1:0]            REQ_RDY,
  output logic [DATA_WIDTH-1:0]             RSP_VAL,
  output logic [NUM_CLIENTS-1:0]            RSP_RDY,
  input  logic [NUM_CLIENTS-1:0]            RSP_EN,
  output logic [ADDR_WIDTH-1:0]             RD_ADDR,
  output logic                              RD_EN,
  input  logic                              RD_RDY,
  input  logic [DATA_WIDTH-1:0]             RES,
  input  logic                              RES_RDY,
  output logic                              RES_EN
);

  localparam int                     TAG_WIDTH   = clog2_min1(NUM_CLIENTS);
  localparam int                     COUNT_WIDTH = count_width(TAG_DEPTH);
  localparam logic [COUNT_WIDTH-1:0] TAG_DEPTH_C = COUNT_WIDTH'(TAG_DEPTH);
  localparam logic [TAG_WIDTH-1:0]   LAST_CLIENT = TAG_WIDTH'(NUM_CLIENTS - 1);

  logic [NUM_CLIENTS-1:0] r_buf_valid;
  logic [ADDR_WIDTH-1:0]  r_buf_addr [NUM_CLIENTS];
  logic [TAG_WIDTH-1:0]   r_rr_ptr;

  logic [MAX_CLIENTS-1:0] w_valid_ext;
  logic [MAX_TAG_W-1:0]   w_ptr_ext;
  rr_grant_t              w_grant;
  logic [TAG_WIDTH-1:0]   w_grant_idx;
  logic [TAG_WIDTH-1:0]   w_rr_next;
  logic [NUM_CLIENTS-1:0] w_grant_oh;
  logic                   w_can_issue;
  logic                   w_issue;
  logic [TAG_WIDTH-1:0]   w_head_tag;
  logic [COUNT_WIDTH-1:0] w_count;
  logic                   w_rsp_active;

  assign w_valid_ext = MAX_CLIENTS'(r_buf_valid);
  assign w_ptr_ext   = MAX_TAG_W'(r_rr_ptr);
  assign w_grant     = rr_find_first(w_valid_ext, w_ptr_ext, NUM_CLIENTS);
  assign w_grant_idx = TAG_WIDTH'(w_grant.idx);
  assign w_rr_next   = (w_grant_idx == LAST_CLIENT) ? '0 : w_grant_idx + TAG_WIDTH'(1);

  // A full tag FIFO blocks issue even when a pop happens in the same cycle.
  assign w_can_issue = RD_RDY && (w_count < TAG_DEPTH_C);
  assign w_issue     = RST_N && w_can_issue && w_grant.found;
  assign w_grant_oh  = w_issue ? (NUM_CLIENTS'(1) << w_grant_idx) : '0;

  assign REQ_RDY = RST_N ? ~r_buf_valid : '0;
  assign RD_EN   = w_issue;
  assign RD_ADDR = r_buf_addr[w_grant_idx];

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_buf_valid <= '0;
      r_rr_ptr    <= '0;
    end else begin
      r_buf_valid <= (r_buf_valid & ~w_grant_oh) | REQ_EN;
      if (w_issue) r_rr_ptr <= w_rr_next;
    end
  end

  for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_buf
    always_ff @(posedge CLK) begin
      if (REQ_EN[i]) r_buf_addr[i] <= REQ_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  bram_arb_tag_fifo #(
    .TAG_DEPTH  (TAG_DEPTH),
    .TAG_WIDTH  (TAG_WIDTH),
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_tag_fifo (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .i_push    (w_issue),
    .i_push_tag(w_grant_idx),
    .i_pop     (RES_EN),
    .o_head_tag(w_head_tag),
    .o_count   (w_count)
  );

  // Responses come back strictly in issue order, so the head tag names the owner.
  assign w_rsp_active = RST_N && RES_RDY && (w_count != '0);
  assign RSP_RDY      = w_rsp_active ? (NUM_CLIENTS'(1) << w_head_tag) : '0;
  assign RSP_VAL      = RES;
  assign RES_EN       = |(RSP_EN & RSP_RDY);

  a_res_needs_tag: assert property (@(posedge CLK) disable iff (!RST_N)
    !(RES_RDY && (w_count == '0)));

endmodule

// File: tb/tb_bram_read_arbiter.sv
// Bench for bram_read_arbiter: BRAM behavioural stand-in, queue-based reference
// model checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_bram_read_arbiter;

  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int TD = 4;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_en;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_rdy;
  logic [DW-1:0]   rsp_val;
  logic [N-1:0]    rsp_rdy;
  logic [N-1:0]    rsp_en;
  logic [AW-1:0]   rd_addr;
  logic            rd_en;
  logic            rd_rdy;
  logic [DW-1:0]   res_data;
  logic            res_rdy;
  logic            res_en;
  logic            rd_knob;

  int checks = 0;
  int errors = 0;

  bram_read_arbiter #(
    .NUM_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_DEPTH(TD)
  ) dut (
    .CLK(clk), .RST_N(rst_n),
    .REQ_EN(req_en), .REQ_ADDR(req_addr), .REQ_RDY(req_rdy),
    .RSP_VAL(rsp_val), .RSP_RDY(rsp_rdy), .RSP_EN(rsp_en),
    .RD_ADDR(rd_addr), .RD_EN(rd_en), .RD_RDY(rd_rdy),
    .RES(res_data), .RES_RDY(res_rdy), .RES_EN(res_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM stand-in: read accepted in cycle c is visible at the response FIFO head in c+2.
  logic [DW-1:0] mem [1024];
  logic          p_vld;
  logic [DW-1:0] p_data;
  logic [DW-1:0] bf [4];
  int            bh;
  int            bcnt;

  assign rd_rdy   = rd_knob;
  assign res_rdy  = (bcnt != 0);
  assign res_data = bf[bh];

  always @(posedge clk) begin
    if (!rst_n) begin
      p_vld <= 1'b0;
      bh    <= 0;
      bcnt  <= 0;
    end else begin
      p_vld  <= rd_en && rd_rdy;
      p_data <= mem[rd_addr];
      if (p_vld) bf[(bh + bcnt) % 4] <= p_data;
      if (res_en && bcnt != 0) bh <= (bh + 1) % 4;
      bcnt <= bcnt + (p_vld ? 1 : 0) - ((res_en && bcnt != 0) ? 1 : 0);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: buffers, round-robin pointer, and queues of in-flight owners/data.
  bit          m_valid [N];
  logic [9:0]  m_addr  [N];
  int          m_rr;
  int          m_tag [$];
  logic [31:0] m_dat [$];
  logic [3:0]  e_req_rdy;
  logic [3:0]  e_rsp_rdy;
  logic        e_res_en;
  int          m_g;

  initial begin
    m_rr = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        chk("rst_req_rdy", 64'(req_rdy), 64'd0);
        chk("rst_rd_en",   64'(rd_en),   64'd0);
        chk("rst_rsp_rdy", 64'(rsp_rdy), 64'd0);
        chk("rst_res_en",  64'(res_en),  64'd0);
        for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
        m_rr = 0;
        m_tag.delete();
        m_dat.delete();
      end else begin
        for (int i = 0; i < N; i++) e_req_rdy[i] = !m_valid[i];
        m_g = -1;
        if (rd_rdy && m_tag.size() < TD) begin
          for (int k = 0; k < N; k++) begin
            if (m_g < 0 && m_valid[(m_rr + k) % N]) m_g = (m_rr + k) % N;
          end
        end
        e_rsp_rdy = (res_rdy && m_tag.size() > 0) ? 4'(1 << m_tag[0]) : 4'd0;
        e_res_en  = |(rsp_en & e_rsp_rdy);
        chk("m_req_rdy", 64'(req_rdy), 64'(e_req_rdy));
        chk("m_rd_en",   64'(rd_en),   64'(m_g >= 0));
        if (m_g >= 0) chk("m_rd_addr", 64'(rd_addr), 64'(m_addr[m_g]));
        chk("m_rsp_rdy", 64'(rsp_rdy), 64'(e_rsp_rdy));
        if (e_rsp_rdy != 4'd0) chk("m_rsp_val", 64'(rsp_val), 64'(m_dat[0]));
        chk("m_res_en",  64'(res_en),  64'(e_res_en));
        if (e_res_en) begin
          void'(m_tag.pop_front());
          void'(m_dat.pop_front());
        end
        if (m_g >= 0) begin
          m_valid[m_g] = 1'b0;
          m_tag.push_back(m_g);
          m_dat.push_back(mem[m_addr[m_g]]);
          m_rr = (m_g + 1) % N;
        end
        for (int i = 0; i < N; i++) begin
          if (req_en[i]) begin
            m_valid[i] = 1'b1;
            m_addr[i]  = req_addr[i*AW +: AW];
          end
        end
      end
    end
  end

  task automatic next_cycle();
    @(negedge clk);
    req_en = '0;
    rsp_en = '0;
  endtask

  task automatic drain(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      next_cycle();
      rsp_en = rsp_rdy;
    end
  endtask

  int rst_hold;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[5]   = 32'hDEAD;
    rst_n    = 1'b0;
    req_en   = '0;
    req_addr = '0;
    rsp_en   = '0;
    rd_knob  = 1'b1;

    // Reset held for three cycles.
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      #1;
      chk("reset_req_rdy", 64'(req_rdy), 64'h0);
      chk("reset_rd_en",   64'(rd_en),   64'h0);
    end
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    #1;
    chk("post_reset_req_rdy", 64'(req_rdy), 64'hF);

    // Single read by client 2 from address 5.
    next_cycle();
    req_en[2] = 1'b1;
    req_addr[2*AW +: AW] = 10'd5;
    #1;
    chk("single_req_rdy_t", 64'(req_rdy), 64'hF);
    next_cycle();
    #1;
    chk("single_rd_en",    64'(rd_en),   64'd1);
    chk("single_rd_addr",  64'(rd_addr), 64'd5);
    chk("single_req_rdy",  64'(req_rdy), 64'hB);
    next_cycle();
    #1;
    chk("single_idle_rd",  64'(rd_en),   64'd0);
    chk("single_idle_rsp", 64'(rsp_rdy), 64'd0);
    next_cycle();
    rsp_en[2] = 1'b1;
    #1;
    chk("single_rsp_rdy",  64'(rsp_rdy), 64'h4);
    chk("single_rsp_val",  64'(rsp_val), 64'hDEAD);
    chk("single_res_en",   64'(res_en),  64'd1);
    next_cycle();
    #1;
    chk("single_rsp_gone", 64'(rsp_rdy), 64'd0);

    // Reset so the round-robin pointer starts at client 0.
    next_cycle();
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;

    // All four clients at once: grants 0,1,2,3 and responses in the same order.
    next_cycle();
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'(10 + i);
    req_en = 4'hF;
    for (int c = 1; c <= 7; c++) begin
      next_cycle();
      rsp_en = rsp_rdy;
      #1;
      if (c <= 4) begin
        chk("rr_rd_en",   64'(rd_en),   64'd1);
        chk("rr_rd_addr", 64'(rd_addr), 64'(10 + c - 1));
      end
      if (c >= 3 && c <= 6) begin
        chk("rr_rsp_rdy", 64'(rsp_rdy), 64'(1 << (c - 3)));
        chk("rr_rsp_val", 64'(rsp_val), 64'(mem[10 + c - 3]));
      end
      if (c == 7) chk("rr_rsp_done", 64'(rsp_rdy), 64'd0);
    end

    // Tag FIFO full: four reads outstanding, fifth buffered request waits.
    next_cycle();
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'(20 + i);
    req_en = 4'hF;
    next_cycle();
    next_cycle();
    req_en[0] = 1'b1;
    req_addr[0 +: AW] = 10'd30;
    next_cycle();
    next_cycle();
    for (int c = 5; c <= 7; c++) begin
      next_cycle();
      #1;
      chk("full_rd_en",    64'(rd_en),      64'd0);
      chk("full_req_rdy0", 64'(req_rdy[0]), 64'd0);
      chk("full_rsp_rdy",  64'(rsp_rdy),    64'h1);
    end
    next_cycle();
    rsp_en[0] = 1'b1;
    #1;
    chk("full_pop_rd_en",  64'(rd_en),  64'd0);
    chk("full_pop_res_en", 64'(res_en), 64'd1);
    next_cycle();
    #1;
    chk("full_after_rd_en",   64'(rd_en),   64'd1);
    chk("full_after_rd_addr", 64'(rd_addr), 64'd30);
    drain(14);

    // Backpressure from the BRAM with clients 1 and 3 buffered.
    next_cycle();
    rd_knob = 1'b0;
    req_addr[1*AW +: AW] = 10'd40;
    req_addr[3*AW +: AW] = 10'd41;
    req_en = 4'b1010;
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      #1;
      chk("bp_rd_en",     64'(rd_en),      64'd0);
      chk("bp_req_rdy13", 64'({req_rdy[3], req_rdy[1]}), 64'd0);
    end
    next_cycle();
    rd_knob = 1'b1;
    #1;
    chk("bp_rel_rd_en1", 64'(rd_en),   64'd1);
    chk("bp_rel_addr1",  64'(rd_addr), 64'd40);
    next_cycle();
    #1;
    chk("bp_rel_rd_en3", 64'(rd_en),   64'd1);
    chk("bp_rel_addr3",  64'(rd_addr), 64'd41);
    drain(10);

    // Head-of-line: client 0 withholds its response, client 1 stays blocked.
    next_cycle();
    req_addr[0 +: AW]  = 10'd50;
    req_addr[AW +: AW] = 10'd51;
    req_en = 4'b0011;
    next_cycle();
    next_cycle();
    for (int c = 3; c <= 6; c++) begin
      next_cycle();
      #1;
      chk("hol_rsp_rdy", 64'(rsp_rdy), 64'h1);
    end
    next_cycle();
    rsp_en[0] = 1'b1;
    #1;
    chk("hol_release", 64'(rsp_rdy), 64'h1);
    next_cycle();
    rsp_en = rsp_rdy;
    #1;
    chk("hol_next_rdy", 64'(rsp_rdy), 64'h2);
    chk("hol_next_val", 64'(rsp_val), 64'(mem[51]));
    drain(6);

    // Random traffic with occasional mid-operation resets.
    rst_hold = 0;
    repeat (3000) begin
      next_cycle();
      if (rst_hold > 0) begin
        rst_n = 1'b0;
        rst_hold--;
      end else if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        rst_hold = 1;
      end else begin
        rst_n = 1'b1;
      end
      if (rst_n) begin
        for (int i = 0; i < N; i++) begin
          if (req_rdy[i] && $urandom_range(0, 2) == 0) begin
            req_en[i] = 1'b1;
            req_addr[i*AW +: AW] = AW'($urandom_range(0, 1023));
          end
        end
        rsp_en = rsp_rdy & 4'($urandom);
      end
      rd_knob = ($urandom_range(0, 9) < 7);
    end
    rst_n = 1'b1;
    rd_knob = 1'b1;
    drain(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
